instr_line_buffer: RTL and testbench

INSTR_LINE_BUFFER -- requirements
Module: instr_line_buffer

---
 rtl/fetch_pkg.sv | 15 +
 rtl/ilb_line_store.sv | 29 ++
 rtl/instr_line_buffer.sv | 145 ++++++++++++++
 tb/tb_instr_line_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: line-buffer states, line geometry and AXI response codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DRAIN   = 2'd2,
        DISCARD = 2'd3
    } ilb_state_e;

    localparam int LINE_BEATS     = 8;
    localparam int WORDS_PER_LINE = 16;
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ilb_line_store.sv
// Cache-line storage: one beat-wide write port and a combinational 32-bit instruction read port.
module ilb_line_store #(
    parameter int LINE_BEATS = 8,
    parameter int DATA_WIDTH = 64,
    localparam int SLOT_W = $clog2(LINE_BEATS),
    localparam int WIDX_W = SLOT_W + 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [SLOT_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [WIDX_W-1:0]     word_idx,
    output logic [31:0]           word
);

    logic [DATA_WIDTH-1:0] mem [LINE_BEATS];
    logic [DATA_WIDTH-1:0] slot;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Even word index is the low half of its beat, odd is the high half.
    assign slot = mem[word_idx[WIDX_W-1:1]];
    assign word = word_idx[0] ? slot[63:32] : slot[31:0];

endmodule

// File: rtl/instr_line_buffer.sv
// Fills one 64-byte instruction line from an AXI wrap burst, then streams its 32-bit
// words starting at the requested PC, with fault, halt and flush handling.
module instr_line_buffer
    import fetch_pkg::*;
#(
    parameter int LINE_BEATS = fetch_pkg::LINE_BEATS,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fill_start,
    input  logic [63:0]           fill_pc,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [63:0]           inst_pc,
    output logic                  inst_fault,
    output logic                  inst_halt,
    input  logic                  flush,
    output logic                  busy,
    output logic                  line_done
);

    localparam int SLOT_W = $clog2(LINE_BEATS);
    localparam int WIDX_W = $clog2(WORDS_PER_LINE);

    ilb_state_e        state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [WIDX_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;

    logic              beat_acc;
    logic              final_beat;
    logic              we;
    logic [SLOT_W-1:0] waddr;
    logic [31:0]       word_rd;

    assign r_ready    = (state_q == FILL) || (state_q == DISCARD);
    assign beat_acc   = r_valid && r_ready;
    assign final_beat = (cnt_q == SLOT_W'(LINE_BEATS - 1));
    // Wrap burst: slot index wraps modulo the power-of-two line size.
    assign waddr      = pc_q[3 +: SLOT_W] + cnt_q;
    assign we         = (state_q == FILL) && beat_acc && !flush;

    ilb_line_store #(
        .LINE_BEATS(LINE_BEATS),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_store (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (r_data),
        .word_idx(idx_q),
        .word    (word_rd)
    );

    assign inst_valid = (state_q == DRAIN);
    assign inst_fault = inst_valid && fault_q;
    assign inst       = (inst_valid && !fault_q) ? word_rd : 32'd0;
    assign inst_pc    = !inst_valid ? 64'd0 :
                        fault_q     ? pc_q  : {pc_q[63:6], idx_q, 2'b00};
    assign inst_halt  = (inst == 32'd0) && !inst_fault;
    assign busy       = (state_q != IDLE);
    assign line_done  = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_start && !flush) begin
                    state_d = FILL;
                    pc_d    = fill_pc;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            FILL: begin
                // A flush on the closing beat has nothing left to drain.
                if (flush) begin
                    state_d = (beat_acc && r_last) ? IDLE : DISCARD;
                end else if (beat_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((r_resp != RESP_OKAY) || (r_last != final_beat)) begin
                        fault_d = 1'b1;
                    end
                    if (final_beat || r_last) begin
                        state_d = DRAIN;
                        idx_d   = pc_q[2 +: WIDX_W];
                    end
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (inst_ready) begin
                    if (fault_q || inst_halt) begin
                        state_d = IDLE;
                    end else if (idx_q == WIDX_W'(WORDS_PER_LINE - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (beat_acc && r_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed bench for instr_line_buffer: normal, wrapped, faulted, flushed, halted and reset fills.
module tb_instr_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_start;
    logic [63:0] fill_pc;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        inst_halt;
    logic        flush;
    logic        busy;
    logic        line_done;

    int n_chk = 0;
    int n_bad = 0;

    instr_line_buffer #(
        .LINE_BEATS(8),
        .DATA_WIDTH(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fill_start(fill_start),
        .fill_pc   (fill_pc),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_fault(inst_fault),
        .inst_halt (inst_halt),
        .flush     (flush),
        .busy      (busy),
        .line_done (line_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word w of a line whose beat k carries {tag|(2k+1), tag|2k}, burst starting at slot pc[5:3].
    function automatic logic [31:0] exp_word(input logic [31:0] tag, input logic [63:0] pc, input int w);
        int k;
        k = ((w >> 1) - int'(pc[5:3])) & 7;
        return tag | 32'(2 * k + (w & 1));
    endfunction

    task automatic start_fill(input logic [63:0] pc);
        fill_pc    = pc;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        chk("fill_busy", busy, 1);
        chk("fill_rready", r_ready, 1);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
        int n;
        n       = 0;
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = resp;
        r_last  = last;
        while (!r_ready && n < 16) begin
            step();
            n++;
        end
        chk("beat_rready", r_ready, 1);
        step();
        r_valid = 1'b0;
        r_resp  = 2'b00;
        r_last  = 1'b0;
    endtask

    task automatic send_line(input logic [31:0] tag, input int bad_k, input int zero_w);
        logic [31:0] lo, hi;
        for (int k = 0; k < 8; k++) begin
            lo = tag | 32'(2 * k);
            hi = tag | 32'(2 * k + 1);
            if (zero_w == 2 * k)     lo = 32'd0;
            if (zero_w == 2 * k + 1) hi = 32'd0;
            send_beat({hi, lo}, (k == bad_k) ? 2'b10 : 2'b00, k == 7);
        end
        chk("latency_valid", inst_valid, 1);
    endtask

    task automatic drain_all(input logic [63:0] pc, input logic [31:0] tag);
        inst_ready = 1'b1;
        for (int w = int'(pc[5:2]); w < 16; w++) begin
            chk("drain_valid", inst_valid, 1);
            chk("drain_inst", inst, exp_word(tag, pc, w));
            chk("drain_pc", inst_pc, {pc[63:6], 4'(w), 2'b00});
            chk("drain_halt", inst_halt, 0);
            chk("drain_done_early", line_done, 0);
            step();
        end
        inst_ready = 1'b0;
        chk("line_done", line_done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", inst_valid, 0);
        step();
        chk("line_done_pulse", line_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        fill_start = 1'b0;
        fill_pc    = '0;
        r_valid    = 1'b0;
        r_data     = '0;
        r_resp     = 2'b00;
        r_last     = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rready", r_ready, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_fault", inst_fault, 0);
        chk("rst_done", line_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Aligned line, all 16 words.
        start_fill(64'h1000);
        send_line(32'hA000_0000, -1, -1);
        drain_all(64'h1000, 32'hA000_0000);

        // Wrapped burst starting at slot 5, words 10..15.
        start_fill(64'h1028);
        send_line(32'hB000_0000, -1, -1);
        drain_all(64'h1028, 32'hB000_0000);

        // Error response on one beat: single fault word.
        start_fill(64'h2014);
        send_line(32'hC000_0000, 3, -1);
        chk("fault_inst", inst, 0);
        chk("fault_flag", inst_fault, 1);
        chk("fault_halt", inst_halt, 0);
        chk("fault_pc", inst_pc, 64'h2014);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("fault_valid_after", inst_valid, 0);
        chk("fault_busy_after", busy, 0);
        chk("fault_no_done", line_done, 0);
        step();
        chk("fault_single", inst_valid, 0);

        // Flush mid-fill: remaining beats are swallowed.
        start_fill(64'h1000);
        send_beat(64'hD000_0001_D000_0000, 2'b00, 1'b0);
        send_beat(64'hD000_0003_D000_0002, 2'b00, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 2; k < 8; k++) begin
            chk("discard_rready", r_ready, 1);
            chk("discard_busy", busy, 1);
            chk("discard_valid", inst_valid, 0);
            send_beat({32'hD000_0000 | 32'(2 * k + 1), 32'hD000_0000 | 32'(2 * k)}, 2'b00, k == 7);
        end
        chk("discard_end_busy", busy, 0);
        chk("discard_end_rready", r_ready, 0);
        chk("discard_end_valid", inst_valid, 0);
        step();
        chk("discard_idle_valid", inst_valid, 0);

        // Stalling consumer with a halt word at index 4.
        start_fill(64'h1000);
        send_line(32'hE000_0000, -1, 4);
        for (int w = 0; w < 5; w++) begin
            inst_ready = 1'b0;
            chk("stall_inst", inst, (w == 4) ? 32'd0 : (32'hE000_0000 | 32'(w)));
            chk("stall_pc", inst_pc, 64'h1000 + 64'(4 * w));
            step();
            chk("stall_hold_valid", inst_valid, 1);
            chk("stall_hold_inst", inst, (w == 4) ? 32'd0 : (32'hE000_0000 | 32'(w)));
            chk("stall_hold_pc", inst_pc, 64'h1000 + 64'(4 * w));
            chk("stall_halt", inst_halt, (w == 4) ? 1 : 0);
            inst_ready = 1'b1;
            step();
        end
        inst_ready = 1'b0;
        chk("halt_valid_after", inst_valid, 0);
        chk("halt_busy_after", busy, 0);
        chk("halt_no_done", line_done, 0);
        step();
        chk("halt_no_more", inst_valid, 0);

        // Asynchronous reset while word 7 is presented.
        start_fill(64'h1000);
        send_line(32'hF000_0000, -1, -1);
        inst_ready = 1'b1;
        repeat (7) step();
        chk("pre_rst_inst", inst, 32'hF000_0007);
        chk("pre_rst_pc", inst_pc, 64'h101C);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rready", r_ready, 0);
        chk("arst_inst", inst, 0);
        chk("arst_pc", inst_pc, 0);
        chk("arst_done", line_done, 0);
        inst_ready = 1'b0;
        step();
        reset   = 1'b0;
        r_valid = 1'b1;
        r_last  = 1'b1;
        r_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("stray_rready", r_ready, 0);
        step();
        chk("stray_busy", busy, 0);
        chk("stray_valid", inst_valid, 0);
        r_valid = 1'b0;
        r_last  = 1'b0;
        start_fill(64'h1000);
        send_line(32'h5000_0000, -1, -1);
        drain_all(64'h1000, 32'h5000_0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
